// File: rtl/seq_alu_pkg.sv
// Purpose : shared op codes and FSM state type for the sequential ALU.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

   // Operation codes on the 4-bit op bus; 0, 14 and 15 are illegal.
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_MUL  = 4'd3;
   localparam logic [3:0] OP_DIV  = 4'd4;
   localparam logic [3:0] OP_SHR  = 4'd5;
   localparam logic [3:0] OP_SHRA = 4'd6;
   localparam logic [3:0] OP_SHL  = 4'd7;
   localparam logic [3:0] OP_ROR  = 4'd8;
   localparam logic [3:0] OP_ROL  = 4'd9;
   localparam logic [3:0] OP_AND  = 4'd10;
   localparam logic [3:0] OP_OR   = 4'd11;
   localparam logic [3:0] OP_NEG  = 4'd12;
   localparam logic [3:0] OP_NOT  = 4'd13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Purpose : control-unit <-> ALU request/result bundle.
// Latency : n/a (wires only). Ports: start/op/A/B (request), busy/done/C (+z/n/v/dz with ALU_FLAGS_EN).
// Backpressure: none; the requester watches busy/done and only pulses start when the ALU is idle.
interface seq_alu_if #(
   parameter int W = 32
);
   logic           start;
   logic [3:0]     op;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic           busy;
   logic           done;
   logic [2*W-1:0] C;
`ifdef ALU_FLAGS_EN
   logic           z;
   logic           n;
   logic           v;
   logic           dz;

   modport master (output start, op, A, B, input busy, done, C, z, n, v, dz);
   modport slave  (input start, op, A, B, output busy, done, C, z, n, v, dz);
`else
   modport master (output start, op, A, B, input busy, done, C);
   modport slave  (input start, op, A, B, output busy, done, C);
`endif
endinterface

// File: rtl/seq_muldiv.sv
// Purpose : iterative signed core: radix-2 Booth multiply or restoring divide (magnitude + sign fix-up).
// Latency : go at cycle t loads operands; W steps run t+1..t+W, fin and hi/lo valid combinationally at t+W.
// Backpressure: none; go while a run is active restarts the core with the new operands.
// Ports: clk, rst (sync, active high), go, is_div, a, b -> hi, lo, fin.
module seq_muldiv #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         go,
   input  logic         is_div,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic         fin
);
   localparam int CW = $clog2(W);

   // r: Booth accumulator (one guard bit) or partial remainder
   // x: Booth multiplier / shifting dividend that fills with quotient bits
   // m: multiplicand or divisor magnitude
   logic [W:0]    r_q, r_d;
   logic [W-1:0]  x_q, x_d;
   logic [W-1:0]  m_q, m_d;
   logic          e_q, e_d;        // Booth q[-1] bit
   logic          div_q, div_d;
   logic          negq_q, negq_d;  // quotient must be negated
   logic          negr_q, negr_d;  // remainder must be negated
   logic          act_q, act_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [W:0]    r_s, sum, sh, m_ext;
   logic [W-1:0]  x_s;
   logic          e_s, qbit;

   // One iteration of whichever algorithm is loaded.
   always_comb begin
      m_ext = {m_q[W-1], m_q};
      sum   = r_q;
      sh    = '0;
      qbit  = 1'b0;
      r_s   = r_q;
      x_s   = x_q;
      e_s   = e_q;
      if (div_q) begin
         sh   = {r_q[W-1:0], x_q[W-1]};
         qbit = (sh >= {1'b0, m_q});
         r_s  = qbit ? (sh - {1'b0, m_q}) : sh;
         x_s  = {x_q[W-2:0], qbit};
      end else begin
         case ({x_q[0], e_q})
            2'b01:   sum = r_q + m_ext;
            2'b10:   sum = r_q - m_ext;
            default: sum = r_q;
         endcase
         // arithmetic shift right of {acc, multiplier, q[-1]}
         r_s = {sum[W], sum[W:1]};
         x_s = {sum[0], x_q[W-1:1]};
         e_s = x_q[0];
      end
   end

   assign fin = act_q && (cnt_q == CW'(W - 1));

   // Outputs reflect the final step so the owner can register them on the fin edge.
   always_comb begin
      lo = x_s;
      hi = r_s[W-1:0];
      if (div_q) begin
         lo = negq_q ? (-x_s) : x_s;
         hi = negr_q ? (-r_s[W-1:0]) : r_s[W-1:0];
      end
   end

   always_comb begin
      r_d    = r_q;
      x_d    = x_q;
      m_d    = m_q;
      e_d    = e_q;
      div_d  = div_q;
      negq_d = negq_q;
      negr_d = negr_q;
      act_d  = act_q;
      cnt_d  = cnt_q;
      if (go) begin
         r_d    = '0;
         e_d    = 1'b0;
         div_d  = is_div;
         act_d  = 1'b1;
         cnt_d  = '0;
         negq_d = is_div & (a[W-1] ^ b[W-1]);
         negr_d = is_div & a[W-1];
         if (is_div) begin
            x_d = a[W-1] ? (-a) : a;
            m_d = b[W-1] ? (-b) : b;
         end else begin
            x_d = a;
            m_d = b;
         end
      end else if (act_q) begin
         r_d   = r_s;
         x_d   = x_s;
         e_d   = e_s;
         cnt_d = cnt_q + 1'b1;
         if (fin) act_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q    <= '0;
         x_q    <= '0;
         m_q    <= '0;
         e_q    <= 1'b0;
         div_q  <= 1'b0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
         act_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         r_q    <= r_d;
         x_q    <= x_d;
         m_q    <= m_d;
         e_q    <= e_d;
         div_q  <= div_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
         act_q  <= act_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Purpose : multi-cycle ALU (FSM, simple-op datapath, result register); optional flags with ALU_FLAGS_EN.
// Latency : simple ops and DIV by zero done at t+1; MUL/DIV busy t+1..t+W, done at t+W+1.
// Backpressure: start is only honoured in IDLE; anything else is dropped, never queued.
// Ports: clk, rst (sync, active high), bus (seq_alu_if.slave: start/op/A/B in, busy/done/C out).
module seq_alu #(
   parameter int W = 32
) (
   input  logic   clk,
   input  logic   rst,
   seq_alu_if.slave bus
);
   import alu_pkg::*;

   localparam logic [W-1:0] WV = W'(W);

   state_t         state_q, state_d;
   logic [2*W-1:0] c_q, c_d;
   logic           go, fin;
   logic [W-1:0]   md_hi, md_lo;
   logic [W-1:0]   amt, add_r, sub_r, neg_r, simple_lo;

   seq_muldiv #(.W(W)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .go     (go),
      .is_div (bus.op == OP_DIV),
      .a      (bus.A),
      .b      (bus.B),
      .hi     (md_hi),
      .lo     (md_lo),
      .fin    (fin)
   );

   // Single-cycle datapath, evaluated on the request inputs in the accept cycle.
   // B mod W equals the low $clog2(W) bits of B whenever W is a power of two.
   always_comb begin
      amt   = bus.B % WV;
      add_r = bus.A + bus.B;
      sub_r = bus.A - bus.B;
      neg_r = '0 - bus.A;
      case (bus.op)
         OP_ADD:  simple_lo = add_r;
         OP_SUB:  simple_lo = sub_r;
         OP_SHR:  simple_lo = bus.A >> amt;
         OP_SHRA: simple_lo = $signed(bus.A) >>> amt;
         OP_SHL:  simple_lo = bus.A << amt;
         // a shift by W-0 = W yields zero, so amt 0 returns A unchanged
         OP_ROR:  simple_lo = (bus.A >> amt) | (bus.A << (WV - amt));
         OP_ROL:  simple_lo = (bus.A << amt) | (bus.A >> (WV - amt));
         OP_AND:  simple_lo = bus.A & bus.B;
         OP_OR:   simple_lo = bus.A | bus.B;
         OP_NEG:  simple_lo = neg_r;
         OP_NOT:  simple_lo = ~bus.A;
         default: simple_lo = '0;  // MUL/DIV use the core; illegal codes give 0
      endcase
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      go      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.op == OP_MUL) begin
                  go      = 1'b1;
                  state_d = MUL;
               end else if (bus.op == OP_DIV && bus.B != '0) begin
                  go      = 1'b1;
                  state_d = DIV;
               end else begin
                  state_d = DONE;
                  // divide by zero skips the core entirely
                  c_d = (bus.op == OP_DIV) ? {bus.A, {W{1'b1}}} : {{W{1'b0}}, simple_lo};
               end
            end
         end
         MUL, DIV: begin
            if (fin) begin
               c_d     = {md_hi, md_lo};
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
      end
   end

   assign bus.busy = (state_q == MUL) || (state_q == DIV);
   assign bus.done = (state_q == DONE);
   assign bus.C    = c_q;

`ifdef ALU_FLAGS_EN
   logic z_q, z_d, n_q, n_d, v_q, v_d, dz_q, dz_d;
   logic ovf, idle_simple;

   always_comb begin
      case (bus.op)
         OP_ADD:  ovf = (bus.A[W-1] == bus.B[W-1]) && (add_r[W-1] != bus.A[W-1]);
         OP_SUB:  ovf = (bus.A[W-1] != bus.B[W-1]) && (sub_r[W-1] != bus.A[W-1]);
         OP_NEG:  ovf = (bus.A == {1'b1, {(W-1){1'b0}}});
         default: ovf = 1'b0;
      endcase
   end

   // Flags load exactly when C loads, i.e. on the edge into DONE.
   always_comb begin
      z_d  = z_q;
      n_d  = n_q;
      v_d  = v_q;
      dz_d = dz_q;
      idle_simple = (state_q == IDLE) && (bus.op != OP_MUL) && (bus.op != OP_DIV);
      if (state_d == DONE && state_q != DONE) begin
         z_d  = (c_d == '0);
         n_d  = idle_simple ? c_d[W-1] : c_d[2*W-1];
         v_d  = (state_q == IDLE) && ovf;
         dz_d = (state_q == IDLE) && (bus.op == OP_DIV);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         z_q  <= 1'b0;
         n_q  <= 1'b0;
         v_q  <= 1'b0;
         dz_q <= 1'b0;
      end else begin
         z_q  <= z_d;
         n_q  <= n_d;
         v_q  <= v_d;
         dz_q <= dz_d;
      end
   end

   assign bus.z  = z_q;
   assign bus.n  = n_q;
   assign bus.v  = v_q;
   assign bus.dz = dz_q;
`endif

endmodule
